// File: rtl/lcd_pkg.sv
// Shared types and HD44780 constants for the character-LCD bus arbiter
// and the content writers that feed it.
package lcd_pkg;

    // Bus transaction sequencer states.
    typedef enum logic [2:0] {
        S_POR,
        S_IDLE,
        S_W_SETUP,
        S_W_PULSE,
        S_W_HOLD,
        S_B_SETUP,
        S_B_PULSE,
        S_B_HOLD
    } state_t;

    // One byte queued for the panel: rs=0 instruction, rs=1 data.
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_req_t;

    // HD44780 instruction encodings.
    localparam logic [7:0] HD_CLEAR    = 8'h01;
    localparam logic [7:0] HD_HOME     = 8'h02;
    localparam logic [7:0] HD_ENTRY    = 8'h06;
    localparam logic [7:0] HD_DISP_ON  = 8'h0C;
    localparam logic [7:0] HD_FUNC_SET = 8'h38;
    localparam logic [7:0] HD_DDRAM    = 8'h80;

    // Set-DDRAM-address instruction; line 1 starts at address 0x40.
    function automatic logic [7:0] ddram_addr(
        input logic       line,
        input logic [5:0] col
    );
        return HD_DDRAM | {1'b0, line, col};
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant for the LCD bus requesters.
// Ports: i_clk, i_rst (sync, active-high); i_en opens the grant window;
//   i_a_valid/i_b_valid requests; o_a_grant/o_b_grant one-hot grants.
module lcd_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_a_valid,
    input  logic i_b_valid,
    output logic o_a_grant,
    output logic o_b_grant
);

    // prio_b=0: A wins a tie. Each grant hands priority to the
    // other requester, so a tie always goes to the one not served last.
    logic prio_b;

    always_comb begin
        o_a_grant = i_en & i_a_valid & (~i_b_valid | ~prio_b);
        o_b_grant = i_en & i_b_valid & (~i_a_valid | prio_b);
    end

    // A grant implies valid, so it is also the accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio_b <= 1'b0;
        end else if (o_a_grant) begin
            prio_b <= 1'b1;
        end else if (o_b_grant) begin
            prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780 8-bit bus arbiter: two byte writers share the panel; each byte
// runs write strobe then busy-flag polling until the panel is ready.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_a_valid/rs/data, o_a_ready   requester A (status/menu line)
//   i_b_valid/rs/data, o_b_ready   requester B (time/counter)
//   o_busy                    transaction or power-on wait running
//   o_LCD_EN/RS/RW            panel control pins
//   o_LCD_DATA, o_LCD_DATA_OE pad drive value and output enable
//   i_LCD_DATA                pad readback, bit 7 is the busy flag
//   o_bf_err                  sticky busy-flag timeout
// Optional: define LCD_BF_TIMEOUT_EN to bound busy-flag polling to
//   BF_TIMEOUT cycles; otherwise polling is unbounded and o_bf_err is 0.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_PW       = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned POR_WAIT   = 750000,
    parameter int unsigned BF_TIMEOUT = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_valid,
    input  logic       i_a_rs,
    input  logic [7:0] i_a_data,
    output logic       o_a_ready,
    input  logic       i_b_valid,
    input  logic       i_b_rs,
    input  logic [7:0] i_b_data,
    output logic       o_b_ready,
    output logic       o_busy,
    output logic       o_LCD_EN,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic [7:0] o_LCD_DATA,
    output logic       o_LCD_DATA_OE,
    input  logic [7:0] i_LCD_DATA,
    output logic       o_bf_err
);

    localparam logic [19:0] SETUP_END = 20'(T_SETUP - 1);
    localparam logic [19:0] PW_END    = 20'(T_PW - 1);
    localparam logic [19:0] HOLD_END  = 20'(T_HOLD - 1);
    localparam logic [19:0] POR_END   = 20'(POR_WAIT - 1);
    localparam logic [19:0] TO_END    = 20'(BF_TIMEOUT - 1);

    state_t      state;
    state_t      nx_base;
    state_t      state_nx;
    logic [19:0] cnt;
    lcd_req_t    req;
    logic        bf;
    logic        a_grant;
    logic        b_grant;
    logic        in_b;

    // Only the busy flag matters; DB6..DB0 carry the address counter.
    logic unused_rd_bits;
    assign unused_rd_bits = ^i_LCD_DATA[6:0];

    lcd_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (state == S_IDLE),
        .i_a_valid (i_a_valid),
        .i_b_valid (i_b_valid),
        .o_a_grant (a_grant),
        .o_b_grant (b_grant)
    );

    assign o_a_ready = a_grant;
    assign o_b_ready = b_grant;
    assign o_busy    = (state != S_IDLE);
    assign in_b      = (state == S_B_SETUP) ||
                       (state == S_B_PULSE) ||
                       (state == S_B_HOLD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_POR;
            cnt   <= '0;
            req   <= '0;
            bf    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
            if (a_grant) begin
                req <= '{rs: i_a_rs, data: i_a_data};
            end else if (b_grant) begin
                req <= '{rs: i_b_rs, data: i_b_data};
            end
            if (state == S_B_PULSE && cnt == PW_END) begin
                bf <= i_LCD_DATA[7];
            end
        end
    end

    // Next state and pin decode. Pins follow the state register
    // directly, so a reset edge drops EN in the cycle that follows.
    always_comb begin
        nx_base       = state;
        o_LCD_EN      = 1'b0;
        o_LCD_RS      = 1'b0;
        o_LCD_RW      = 1'b0;
        o_LCD_DATA    = 8'h00;
        o_LCD_DATA_OE = 1'b0;
        unique case (state)
            S_POR: begin
                if (cnt == POR_END) nx_base = S_IDLE;
            end
            S_IDLE: begin
                if (a_grant || b_grant) nx_base = S_W_SETUP;
            end
            S_W_SETUP: begin
                o_LCD_RS      = req.rs;
                o_LCD_DATA    = req.data;
                o_LCD_DATA_OE = 1'b1;
                if (cnt == SETUP_END) nx_base = S_W_PULSE;
            end
            S_W_PULSE: begin
                o_LCD_EN      = 1'b1;
                o_LCD_RS      = req.rs;
                o_LCD_DATA    = req.data;
                o_LCD_DATA_OE = 1'b1;
                if (cnt == PW_END) nx_base = S_W_HOLD;
            end
            S_W_HOLD: begin
                o_LCD_RS      = req.rs;
                o_LCD_DATA    = req.data;
                o_LCD_DATA_OE = 1'b1;
                if (cnt == HOLD_END) nx_base = S_B_SETUP;
            end
            S_B_SETUP: begin
                o_LCD_RW = 1'b1;
                if (cnt == SETUP_END) nx_base = S_B_PULSE;
            end
            S_B_PULSE: begin
                o_LCD_EN = 1'b1;
                o_LCD_RW = 1'b1;
                if (cnt == PW_END) nx_base = S_B_HOLD;
            end
            S_B_HOLD: begin
                o_LCD_RW = 1'b1;
                if (cnt == HOLD_END) begin
                    nx_base = bf ? S_B_SETUP : S_IDLE;
                end
            end
            default: nx_base = S_POR;
        endcase
    end

`ifdef LCD_BF_TIMEOUT_EN
    logic [19:0] poll_cnt;
    logic        bf_err_q;
    logic        to_hit;

    // Forced release only when the poll would otherwise continue; a
    // clean exit on the last allowed cycle is not an error.
    always_comb begin
        state_nx = nx_base;
        to_hit   = 1'b0;
        if (in_b && poll_cnt == TO_END && nx_base != S_IDLE) begin
            state_nx = S_IDLE;
            to_hit   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            poll_cnt <= '0;
            bf_err_q <= 1'b0;
        end else begin
            poll_cnt <= in_b ? poll_cnt + 20'd1 : 20'd0;
            if (to_hit) bf_err_q <= 1'b1;
        end
    end

    assign o_bf_err = bf_err_q;
`else
    logic unused_to_cfg;
    assign unused_to_cfg = ^TO_END ^ in_b;
    assign state_nx      = nx_base;
    assign o_bf_err      = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomised bench for lcd_bus_arbiter against a transaction-level model
// that expands each accepted byte into its expected per-cycle bus pattern.
module tb_lcd_bus_arbiter;

    localparam int T_SETUP    = 1;
    localparam int T_PW       = 2;
    localparam int T_HOLD     = 1;
    localparam int POR_WAIT   = 10;
    localparam int BF_TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_a_valid, i_a_rs, o_a_ready;
    logic [7:0] i_a_data;
    logic       i_b_valid, i_b_rs, o_b_ready;
    logic [7:0] i_b_data;
    logic       o_busy, o_LCD_EN, o_LCD_RS, o_LCD_RW, o_LCD_DATA_OE;
    logic [7:0] o_LCD_DATA, i_LCD_DATA;
    logic       o_bf_err;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .T_SETUP    (T_SETUP),
        .T_PW       (T_PW),
        .T_HOLD     (T_HOLD),
        .POR_WAIT   (POR_WAIT),
        .BF_TIMEOUT (BF_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_a_valid     (i_a_valid),
        .i_a_rs        (i_a_rs),
        .i_a_data      (i_a_data),
        .o_a_ready     (o_a_ready),
        .i_b_valid     (i_b_valid),
        .i_b_rs        (i_b_rs),
        .i_b_data      (i_b_data),
        .o_b_ready     (o_b_ready),
        .o_busy        (o_busy),
        .o_LCD_EN      (o_LCD_EN),
        .o_LCD_RS      (o_LCD_RS),
        .o_LCD_RW      (o_LCD_RW),
        .o_LCD_DATA    (o_LCD_DATA),
        .o_LCD_DATA_OE (o_LCD_DATA_OE),
        .i_LCD_DATA    (i_LCD_DATA),
        .o_bf_err      (o_bf_err)
    );

    typedef struct {
        logic       en;
        logic       rs;
        logic       rw;
        logic       oe;
        logic [7:0] data;
        logic       bfv;
        logic       bf;
        logic       set_err;
    } ent_t;

    ent_t       expq[$];
    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic [7:0] wlog[$];
    int         por_left;
    bit         prio_b;
    bit         err_exp;
    bit         armed;
    bit         ga, gb;
    int         next_busy;
    int         nchk, nerr;
    int         w_en, rd, nrw;
    logic       en_d;
    logic       last_ra, last_busy, last_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic en, input logic rs,
                                input logic rw, input logic oe,
                                input logic [7:0] d, input logic bfv,
                                input logic bf);
        ent_t e;
        e.en = en; e.rs = rs; e.rw = rw; e.oe = oe;
        e.data = d; e.bfv = bfv; e.bf = bf; e.set_err = 1'b0;
        return e;
    endfunction

    // One byte: write strobe, then nb busy polls and one ready poll.
    task automatic build(input logic [8:0] r, input int nb);
        ent_t bl[$];
        for (int i = 0; i < T_SETUP; i++)
            expq.push_back(mk(0, r[8], 0, 1, r[7:0], 0, 0));
        for (int i = 0; i < T_PW; i++)
            expq.push_back(mk(1, r[8], 0, 1, r[7:0], 0, 0));
        for (int i = 0; i < T_HOLD; i++)
            expq.push_back(mk(0, r[8], 0, 1, r[7:0], 0, 0));
        for (int p = 0; p <= nb; p++) begin
            for (int i = 0; i < T_SETUP; i++)
                bl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0));
            for (int i = 0; i < T_PW; i++)
                bl.push_back(mk(1, 0, 1, 0, 8'h00, i == T_PW - 1, p < nb));
            for (int i = 0; i < T_HOLD; i++)
                bl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0));
        end
`ifdef LCD_BF_TIMEOUT_EN
        if (bl.size() > BF_TIMEOUT) begin
            while (bl.size() > BF_TIMEOUT) void'(bl.pop_back());
            bl[BF_TIMEOUT-1].set_err = 1'b1;
        end
`endif
        foreach (bl[i]) expq.push_back(bl[i]);
    endtask

    task automatic drive();
        logic bfb;
        i_a_valid = a_q.size() > 0;
        if (i_a_valid) {i_a_rs, i_a_data} = a_q[0];
        else {i_a_rs, i_a_data} = 9'($urandom);
        i_b_valid = b_q.size() > 0;
        if (i_b_valid) {i_b_rs, i_b_data} = b_q[0];
        else {i_b_rs, i_b_data} = 9'($urandom);
        bfb = 1'($urandom);
        if (expq.size() > 0 && expq[0].bfv) bfb = expq[0].bf;
        i_LCD_DATA = {bfb, 7'($urandom)};
    endtask

    task automatic compare();
        logic av, bv, eb, een, eoe;
        ent_t e;
        av = a_q.size() > 0;
        bv = b_q.size() > 0;
        ga = 0;
        gb = 0;
        if (o_LCD_EN && !en_d) begin
            if (o_LCD_RW) rd++;
            else wlog.push_back(o_LCD_DATA);
        end
        if (o_LCD_EN && !o_LCD_RW) w_en++;
        if (o_LCD_RW && o_busy) nrw++;
        en_d      = o_LCD_EN;
        last_ra   = o_a_ready;
        last_busy = o_busy;
        last_en   = o_LCD_EN;
        if (!armed) return;
        if (por_left > 0) begin
            eb = 1; een = 0; eoe = 0;
        end else if (expq.size() > 0) begin
            e = expq[0];
            eb = 1; een = e.en; eoe = e.oe;
            chk("rw", o_LCD_RW, e.rw);
            chk("rs", o_LCD_RS, e.rs);
            if (e.oe) chk("data", o_LCD_DATA, e.data);
        end else begin
            eb = 0; een = 0; eoe = 0;
            ga = av && (!bv || !prio_b);
            gb = bv && (!av || prio_b);
        end
        chk("busy", o_busy, eb);
        chk("en", o_LCD_EN, een);
        chk("oe", o_LCD_DATA_OE, eoe);
        chk("a_ready", o_a_ready, ga);
        chk("b_ready", o_b_ready, gb);
        chk("bf_err", o_bf_err, err_exp);
        chk("oe_with_rw", o_LCD_DATA_OE & o_LCD_RW, 0);
    endtask

    task automatic model_edge();
        ent_t e;
        logic [8:0] r;
        int nb;
        if (i_rst) begin
            armed = 1; por_left = POR_WAIT; expq.delete();
            prio_b = 0; err_exp = 0;
        end else if (!armed) begin
            armed = 0;
        end else if (por_left > 0) begin
            por_left--;
        end else if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.set_err) err_exp = 1;
        end else if (ga || gb) begin
            nb = (next_busy >= 0) ? next_busy : int'($urandom_range(0, 2));
            if (ga) begin
                r = a_q.pop_front(); prio_b = 1;
            end else begin
                r = b_q.pop_front(); prio_b = 0;
            end
            build(r, nb);
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        compare();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int bound, input string nm);
        int n = 0;
        while ((por_left > 0 || expq.size() > 0 || a_q.size() > 0 ||
                b_q.size() > 0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            nchk++; nerr++;
            $display("FAIL %s: model not idle after %0d cycles", nm, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, rise, n, nw;
        logic [7:0] fair_exp[4];
        fair_exp = '{8'h01, 8'h11, 8'h02, 8'h12};
        nchk = 0; nerr = 0; armed = 0; por_left = 0; prio_b = 0;
        err_exp = 0; en_d = 0; w_en = 0; rd = 0; nrw = 0;
        i_rst = 1;
        drive();
        @(posedge clk);
        #1;

        // Reset and power-on wait with A already requesting.
        a_q.push_back({1'b1, 8'h41});
        next_busy = 0;
        repeat (3) step();
        chk("rst_rs", o_LCD_RS, 0);
        chk("rst_rw", o_LCD_RW, 0);
        chk("rst_data", o_LCD_DATA, 0);
        chk("rst_busy", o_busy, 1);
        chk("rst_ready", o_a_ready, 0);
        i_rst = 0;
        w_en = 0; rd = 0; wlog.delete();
        k = 0; rise = 0;
        while (rise == 0 && k < 30) begin
            step();
            k++;
            if (last_ra) rise = k;
        end
        chk("por_ready_cycle", rise, 11);

        // Single write, BF clear on the first poll.
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!last_busy) break;
            n++;
        end
        chk("accept_to_idle", n, 8);
        chk("write_en_cycles", w_en, 2);
        chk("read_pulses", rd, 1);
        chk("write_count", wlog.size(), 1);
        chk("first_byte", wlog.size() > 0 ? wlog[0] : 8'hxx, 8'h41);

        // Busy for two polls, then ready.
        rd = 0; next_busy = 2;
        a_q.push_back({1'b0, 8'h80});
        run_idle(100, "retry");
        step();
        chk("retry_read_pulses", rd, 3);

        // Fairness from reset with both requesters streaming.
        i_rst = 1;
        step();
        i_rst = 0;
        next_busy = 0;
        a_q.push_back({1'b1, 8'h01}); a_q.push_back({1'b1, 8'h02});
        b_q.push_back({1'b1, 8'h11}); b_q.push_back({1'b1, 8'h12});
        wlog.delete();
        run_idle(300, "fair");
        chk("fair_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fair_order", wlog.size() > i ? wlog[i] : 8'hxx, fair_exp[i]);

        // Reset while EN is high on a write.
        a_q.push_back({1'b1, 8'hAA});
        n = 0;
        while (!(expq.size() > 0 && expq[0].en && !expq[0].rw) && n < 50) begin
            step();
            n++;
        end
        chk("pulse_reached", n < 50, 1);
        i_rst = 1;
        step();
        i_rst = 0;
        nw = wlog.size();
        step();
        chk("en_after_reset", last_en, 0);
        chk("busy_after_reset", last_busy, 1);
        run_idle(100, "rst_por");
        repeat (5) step();
        chk("byte_discarded", wlog.size(), nw);

        // BF stuck high.
        nrw = 0; next_busy = 8;
        a_q.push_back({1'b0, 8'h01});
        run_idle(200, "timeout");
        step();
`ifdef LCD_BF_TIMEOUT_EN
        chk("poll_cycles", nrw, BF_TIMEOUT);
        chk("bf_err_set", o_bf_err, 1);
`else
        chk("poll_cycles", nrw, 36);
        chk("bf_err_zero", o_bf_err, 0);
`endif
        i_rst = 1;
        step();
        i_rst = 0;
        run_idle(100, "rst2");

        // Random traffic, busy polls and occasional reset.
        next_busy = -1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0 && a_q.size() < 4)
                a_q.push_back(9'($urandom));
            if ($urandom_range(0, 5) == 0 && b_q.size() < 4)
                b_q.push_back(9'($urandom));
            if ($urandom_range(0, 299) == 0) i_rst = 1;
            step();
            i_rst = 0;
        end
        run_idle(2000, "drain");
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the character-LCD (HD44780-compatible, 8-bit) bus between two write requesters: A is the status/menu line writer and B is the time/counter writer.
- Runs each granted byte as a complete bus transaction: RS/RW setup, EN pulse, hold, then busy-flag (BF) polling until the panel is ready.
- Sits between the display-content FSMs and the LCD pins; the top level owns the tristate buffer on the data bus.

Parameters:
- T_SETUP, 2, cycles RS/RW/DATA are stable before EN rises (min 1)
- T_PW, 12, cycles EN is held high (min 1)
- T_HOLD, 2, cycles RS/RW/DATA are held after EN falls (min 1)
- POR_WAIT, 750000, cycles after reset before the first grant (15 ms at 50 MHz)
- BF_TIMEOUT, 100000, max BF poll cycles before forced release (used only with LCD_BF_TIMEOUT_EN)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_a_valid  in  1  requester A has a byte
- i_a_rs  in  1  A register select (0 = instruction, 1 = data)
- i_a_data  in  8  A byte
- o_a_ready  out  1  A byte accepted this cycle
- i_b_valid, i_b_rs, i_b_data, o_b_ready  as A, for requester B
- o_busy  out  1  a transaction is in progress or the POR wait is running
- o_LCD_EN  out  1  LCD enable
- o_LCD_RS  out  1  LCD register select
- o_LCD_RW  out  1  LCD read/write (1 = read)
- o_LCD_DATA  out  8  write data to the pad
- o_LCD_DATA_OE  out  1  1 = drive the pad, 0 = release it
- i_LCD_DATA  in  8  pad readback (DB7 = BF)
- o_bf_err  out  1  sticky BF-timeout flag (constant 0 without the macro)

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge) sets: state POR, all counters 0, rr pointer = A, and these outputs to 0: EN, RS, RW, DATA, OE, readys, o_bf_err. o_busy resets to 1.
- Reset mid-transaction aborts the transaction in that cycle. EN drops on the next edge and the POR wait restarts.
- POR state: counts POR_WAIT cycles, then goes to IDLE. No ready is asserted during POR.
- IDLE state:
  - o_busy=0.
  - Arbitration is round-robin. If both valid, grant the requester not served last; after reset A wins ties. If only one is valid, it is granted.
  - o_X_ready=1 combinationally for the granted requester only, and only in IDLE.
  - On valid&&ready the arbiter latches {rs, data}, records the winner in rr, and goes to W_SETUP next cycle. At most one accept per transaction; the other requester waits, with its valid held and data stable (AXI-style).
- W_SETUP (T_SETUP cycles): RS=latched rs, RW=0, OE=1, DATA=latched byte, EN=0.
- W_PULSE (T_PW cycles): as W_SETUP with EN=1.
- W_HOLD (T_HOLD cycles): EN=0, bus unchanged.
- Then go to B_SETUP.
- B_SETUP (T_SETUP cycles): RS=0, RW=1, OE=0, EN=0.
- B_PULSE (T_PW cycles): EN=1. i_LCD_DATA[7] is sampled on the last cycle of the pulse.
- B_HOLD (T_HOLD cycles): EN=0. If the sampled BF=1, go to B_SETUP; otherwise go to IDLE with RW=0, OE=0.
- Bus-idle values of RS/RW/DATA are don't-care except OE=0, EN=0.
- OE is never 1 while RW=1, in any cycle.
- A single write with BF clear on the first poll takes 2*(T_SETUP+T_PW+T_HOLD) cycles from accept to IDLE: 32 cycles at defaults.
- Phase counters are 20-bit, saturate-free, and reset to 0 on every state change.
- Input changes outside IDLE are ignored.

Optional Feature:
- Macro: LCD_BF_TIMEOUT_EN.
- Defined: a poll-cycle counter runs across B_* states. When it reaches BF_TIMEOUT, the arbiter goes to IDLE regardless of BF, sets o_bf_err=1 (sticky until i_rst) and emits no retry.
- Undefined: polling is unbounded, o_bf_err is tied to 0, and the counter is not synthesised.

Decomposition:
- Package lcd_pkg holds:
  - the state enum {S_POR, S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_B_SETUP, S_B_PULSE, S_B_HOLD};
  - typedef lcd_req_t {logic rs; logic [7:0] data;};
  - the HD44780 constants (CLEAR, FUNC_SET, DDRAM prefix), shared with the content writers.
- One sub-module, lcd_rr_arb2: a 2-way round-robin grant with a last-served pointer update on accept.

Test Plan (all tests use T_SETUP=1, T_PW=2, T_HOLD=1, POR_WAIT=10, BF_TIMEOUT=20):
- Reset/POR: i_rst 1 → 0 with A valid → o_a_ready stays 0 for 10 cycles, rises on cycle 11; o_busy=1 throughout POR.
- Single write: A sends rs=1, data=8'h41, BF=0 → EN high exactly 2 cycles with RS=1, RW=0, OE=1, DATA=41; a read pulse follows with OE=0; IDLE 8 cycles after accept.
- Busy retry: BF held 1 for 2 poll pulses then 0 → exactly 3 read EN pulses, then IDLE; no OE=1 while RW=1.
- Fairness: A and B continuously valid, A bytes 01,02 and B bytes 11,12 → bus order 01,11,02,12.
- Reset mid-pulse: i_rst during W_PULSE → EN=0 the next cycle, POR restarts, latched byte discarded.
- Timeout (macro on): BF stuck 1 → return to IDLE after 20 poll cycles, o_bf_err=1 until reset; with the macro off the arbiter polls indefinitely.
